// File: rtl/vga_pkg.sv
// VGA timing constants, sync polarity and colour widths shared by the scanout block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default 640x480@60 timing, sync levels, colour field widths,
// the pipeline tag carried alongside each framebuffer read, and a counter
// width helper.
package vga_pkg;

  // Default 640x480@60 timing (25 MHz pixel clock)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Both syncs are active low for this mode
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  // Colour: 4 bits per channel, packed {R,G,B}
  localparam int                COLOR_W   = 4;
  localparam int                RGB_W     = 3 * COLOR_W;
  localparam logic [RGB_W-1:0]  RGB_BLACK = '0;

  // Per-pixel attributes that travel with a read while its data is in flight
  typedef struct packed {
    logic act;  // pixel lies in the active area
    logic hs;   // inside the horizontal sync window
    logic vs;   // inside the vertical sync window
    logic fs;   // first pixel of the frame
  } pix_tag_t;

  // Bits needed for a counter running 0..n-1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port between the scanout engine and the pixel RAM.
// Latency: rd_data returns a fixed number of cycles after rd_en (set by the RAM).
// Backpressure: none; the reader issues one read per active pixel unconditionally.
//
// Signals: rd_en (read strobe), rd_addr (pixel index), rd_data (1-bit pixel).
// master = scanout side, slave = framebuffer side.
interface framebuffer_scanout_if #(
  parameter int ADDR_WIDTH = 19
) ();

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with active, sync and frame-wrap decodes.
// Latency: decodes are combinational from the registered counters (0 cycles).
// Backpressure: none; counters advance every cycle while run_i is high.
//
// Ports: clk, resetn (async active low), run_i (advance counters; held at 0
// otherwise), active_o, in_hsync_o, in_vsync_o (raw window decodes),
// origin_o (counters at 0,0), frame_wrap_o (last pixel of the frame).
module vga_timing import vga_pkg::*; #(
  parameter int SCREEN_WIDTH  = VGA_H_ACTIVE,
  parameter int SCREEN_HEIGHT = VGA_V_ACTIVE,
  parameter int H_FRONT       = VGA_H_FRONT,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BACK        = VGA_H_BACK,
  parameter int V_FRONT       = VGA_V_FRONT,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BACK        = VGA_V_BACK
) (
  input  logic clk,
  input  logic resetn,
  input  logic run_i,
  output logic active_o,
  output logic in_hsync_o,
  output logic in_vsync_o,
  output logic origin_o,
  output logic frame_wrap_o
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(SCREEN_WIDTH);
  localparam logic [HW-1:0] HS_START = HW'(SCREEN_WIDTH + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(SCREEN_HEIGHT);
  localparam logic [VW-1:0] VS_START = VW'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(SCREEN_HEIGHT + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;

  assign h_wrap = (h_cnt_q == H_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_i) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end else begin
      // Idle is only entered on a frame wrap or reset, so this just pins 0,0
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign in_hsync_o   = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign in_vsync_o   = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign origin_o     = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_wrap_o = h_wrap && (v_cnt_q == V_LAST);

endmodule

// File: rtl/framebuffer_scanout.sv
// Scans a 1-bit framebuffer out to VGA: raster timing, sequential reads, colour mapping.
// Latency: RD_LATENCY+1 cycles from raster position to registered hsync/vsync/RGB.
// Backpressure: none; the framebuffer must answer every read after exactly RD_LATENCY cycles.
//
// Ports: clk, resetn (async active low), enable (start/continue scanout,
// acted on only at frame boundaries), fb (framebuffer read master),
// vga_hsync/vga_vsync (active low), vga_r/g/b, vblank (output stage outside
// the active area), frame_start (one-cycle pulse with the first active pixel).
module framebuffer_scanout import vga_pkg::*; #(
  parameter int                SCREEN_WIDTH  = VGA_H_ACTIVE,
  parameter int                SCREEN_HEIGHT = VGA_V_ACTIVE,
  parameter int                H_FRONT       = VGA_H_FRONT,
  parameter int                H_SYNC        = VGA_H_SYNC,
  parameter int                H_BACK        = VGA_H_BACK,
  parameter int                V_FRONT       = VGA_V_FRONT,
  parameter int                V_SYNC        = VGA_V_SYNC,
  parameter int                V_BACK        = VGA_V_BACK,
  parameter int                ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter int                RD_LATENCY    = 1,
  parameter logic [RGB_W-1:0]  FG_COLOR      = 12'hFFF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  framebuffer_scanout_if.master fb,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vblank,
  output logic                 frame_start
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic       run;

  logic       active, in_hsync, in_vsync, origin, frame_wrap;

  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic                  rd_en;

  pix_tag_t   tag0;
  pix_tag_t   tag_q [RD_LATENCY];
  pix_tag_t   tag_rd;

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vblank_q, vblank_d;
  logic             fs_q, fs_d;

  assign run = (state_q == ST_RUN);

  vga_timing #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .H_FRONT       (H_FRONT),
    .H_SYNC        (H_SYNC),
    .H_BACK        (H_BACK),
    .V_FRONT       (V_FRONT),
    .V_SYNC        (V_SYNC),
    .V_BACK        (V_BACK)
  ) u_timing (
    .clk          (clk),
    .resetn       (resetn),
    .run_i        (run),
    .active_o     (active),
    .in_hsync_o   (in_hsync),
    .in_vsync_o   (in_vsync),
    .origin_o     (origin),
    .frame_wrap_o (frame_wrap)
  );

  // Scanout only starts or stops on a frame boundary, so a mid-frame change
  // of enable never produces a partial frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (frame_wrap && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Read side: one read per active pixel, addresses strictly sequential
  assign rd_en = run && active;

  always_comb begin
    addr_cnt_d = addr_cnt_q;
    if (!run || frame_wrap) addr_cnt_d = '0;
    else if (rd_en)         addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) addr_cnt_q <= '0;
    else         addr_cnt_q <= addr_cnt_d;
  end

  assign fb.rd_en   = rd_en;
  assign fb.rd_addr = addr_cnt_q;

  // Raster attributes delayed to line up with rd_data
  always_comb begin
    tag0     = '0;
    tag0.act = run && active;
    tag0.hs  = run && in_hsync;
    tag0.vs  = run && in_vsync;
    tag0.fs  = run && origin;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag0;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_rd = tag_q[RD_LATENCY-1];

  // Output stage: rd_data outside an active slot is don't-care, so colour is
  // forced black whenever the delayed active flag is clear.
  always_comb begin
    rgb_d    = (tag_rd.act && fb.rd_data) ? FG_COLOR : RGB_BLACK;
    hsync_d  = tag_rd.hs ? SYNC_ACTIVE : SYNC_IDLE;
    vsync_d  = tag_rd.vs ? SYNC_ACTIVE : SYNC_IDLE;
    vblank_d = ~tag_rd.act;
    fs_d     = tag_rd.fs;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rgb_q    <= RGB_BLACK;
      hsync_q  <= SYNC_IDLE;
      vsync_q  <= SYNC_IDLE;
      vblank_q <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
      fs_q     <= fs_d;
    end
  end

  assign vga_r       = rgb_q[RGB_W-1 -: COLOR_W];
  assign vga_g       = rgb_q[COLOR_W +: COLOR_W];
  assign vga_b       = rgb_q[0 +: COLOR_W];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Testbench for framebuffer_scanout using a reduced raster so several frames fit in a short run.
// Raster: 16x12 active, 23 pixels x 18 lines total (414 cycles/frame), 1-cycle framebuffer.
// The reference model tracks frame position by cycle count and predicts outputs 2 cycles later.
module tb_framebuffer_scanout;

  localparam int W  = 16, H  = 12;
  localparam int HF = 2,  HS = 3, HB = 2;
  localparam int VF = 2,  VS = 2, VB = 2;
  localparam int HT = W + HF + HS + HB;   // 23
  localparam int VT = H + VF + VS + VB;   // 18
  localparam int FRAME = HT * VT;         // 414
  localparam int AW = $clog2(W * H);      // 8
  localparam logic [11:0] FG = 12'hFFF;
  localparam int NHIST = 8192;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       vga_hsync, vga_vsync, vblank, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  framebuffer_scanout_if #(.ADDR_WIDTH(AW)) fb_if ();

  framebuffer_scanout #(
    .SCREEN_WIDTH (W),  .SCREEN_HEIGHT (H),
    .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .ADDR_WIDTH (AW), .RD_LATENCY (1), .FG_COLOR (FG)
  ) dut (
    .clk (clk), .resetn (resetn), .enable (enable), .fb (fb_if),
    .vga_hsync (vga_hsync), .vga_vsync (vga_vsync),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .vblank (vblank), .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Framebuffer: checkerboard, 1-cycle read; junk on rd_data between reads
  logic ram [W*H];
  always @(posedge clk)
    fb_if.rd_data <= (fb_if.rd_en === 1'b1 && int'(fb_if.rd_addr) < W*H)
                     ? ram[fb_if.rd_addr] : 1'($urandom);

  // Reference model: frame position by cycle count
  typedef struct packed { logic run; logic [15:0] h; logic [15:0] v; } mtag_t;
  bit    m_run = 0;
  int    m_pos = 0;
  mtag_t d1 = '0, d2 = '0;

  function automatic mtag_t cur_tag();
    mtag_t t;
    t.run = m_run;
    t.h   = 16'(m_pos % HT);
    t.v   = 16'(m_pos / HT);
    return t;
  endfunction

  function automatic logic t_act(input mtag_t t);
    return t.run && (t.h < W) && (t.v < H);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_run = 0; m_pos = 0; d1 = '0; d2 = '0;
    end else begin
      d2 = d1;
      d1 = cur_tag();
      if (!m_run) begin
        if (enable) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == FRAME - 1) begin
        m_pos = 0;
        if (!enable) m_run = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Per-cycle compare plus history for the literal timing checks
  logic        hist_hs [NHIST];
  logic        hist_vs [NHIST];
  logic        hist_fs [NHIST];
  logic        hist_en [NHIST];
  logic [AW-1:0] hist_addr [NHIST];
  logic [11:0] hist_rgb [NHIST];

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      mtag_t c;
      logic  e_en;
      logic  e_act;
      c = cur_tag();
      e_en = t_act(c);
      chk("rd_en", fb_if.rd_en, e_en);
      if (e_en || !c.run)
        chk("rd_addr", fb_if.rd_addr, e_en ? int'(c.v) * W + int'(c.h) : 0);
      e_act = t_act(d2);
      chk("hsync", vga_hsync, !(d2.run && d2.h >= W+HF && d2.h < W+HF+HS));
      chk("vsync", vga_vsync, !(d2.run && d2.v >= H+VF && d2.v < H+VF+VS));
      chk("rgb", {vga_r, vga_g, vga_b},
          (e_act && ram[int'(d2.v) * W + int'(d2.h)]) ? FG : 12'h000);
      chk("vblank", vblank, !e_act);
      chk("frame_start", frame_start, d2.run && d2.h == 0 && d2.v == 0);
      if (cyc < NHIST) begin
        hist_hs[cyc] = vga_hsync;  hist_vs[cyc] = vga_vsync;
        hist_fs[cyc] = frame_start; hist_en[cyc] = fb_if.rd_en;
        hist_addr[cyc] = fb_if.rd_addr; hist_rgb[cyc] = {vga_r, vga_g, vga_b};
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"},  fb_if.rd_en, 0);
    chk({tag, "_rd_addr"}, fb_if.rd_addr, 0);
    chk({tag, "_hsync"},  vga_hsync, 1);
    chk({tag, "_vsync"},  vga_vsync, 1);
    chk({tag, "_rgb"},    {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_vblank"}, vblank, 1);
    chk({tag, "_fs"},     frame_start, 0);
  endtask

  // Wait (bounded) until the model sits at a given frame position while running
  task automatic wait_pos(input int pos, input string name);
    bit hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (m_run && m_pos == pos) hit = 1;
    end
    chk(name, hit, 1);
  endtask

  int t_run, t_v5, t_idle, c1, c2, wid, cnt;

  initial begin
    for (int i = 0; i < W*H; i++) ram[i] = 1'(((i / W) + i) % 2);

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    #2 resetn = 1'b1;

    // Stays idle until enable
    repeat (5) @(negedge clk);
    chk("idle_hold_rd_en", fb_if.rd_en, 0);
    chk("idle_hold_vblank", vblank, 1);

    // Start and run two frames
    enable = 1'b1;
    @(posedge clk); #1 t_run = cyc;
    repeat (2 * FRAME + 40) @(negedge clk);

    // Hsync: first low 18+2 cycles after RUN entry, 3 wide, 23 period
    c1 = -1;
    for (int c = t_run; c < t_run + 2*HT && c1 < 0; c++) if (hist_hs[c] === 1'b0) c1 = c;
    chk("hs_first_low_offset", c1 - t_run, 20);
    wid = 0;
    for (int c = c1; c < c1 + HT; c++) if (hist_hs[c] === 1'b0) wid++;
    chk("hs_low_width", wid, HS);
    c2 = -1;
    for (int c = c1 + 1; c < c1 + 2*HT && c2 < 0; c++)
      if (hist_hs[c] === 1'b0 && hist_hs[c-1] === 1'b1) c2 = c;
    chk("hs_period", c2 - c1, 23);

    // Frame_start: at RUN+2, then every 414 cycles, nothing else in two frames
    chk("fs_first", hist_fs[t_run + 2], 1);
    chk("fs_second", hist_fs[t_run + 2 + 414], 1);
    cnt = 0;
    for (int c = t_run; c < t_run + 2*FRAME; c++) if (hist_fs[c] === 1'b1) cnt++;
    chk("fs_count_2frames", cnt, 2);

    // Vsync low 2 lines = 46 cycles per frame; 192 reads per frame
    cnt = 0;
    for (int c = t_run; c < t_run + FRAME; c++) if (hist_vs[c] === 1'b0) cnt++;
    chk("vs_low_cycles", cnt, 46);
    cnt = 0;
    for (int c = t_run; c < t_run + FRAME; c++) if (hist_en[c] === 1'b1) cnt++;
    chk("rd_en_per_frame", cnt, 192);

    // Addresses: line 1 pixel 0, last pixel, nothing after it
    chk("addr_line1_px0", hist_addr[t_run + HT], 16);
    chk("addr_last", hist_addr[t_run + 11*HT + 15], 191);
    chk("rd_en_after_last", hist_en[t_run + 11*HT + 16], 0);

    // Colour: ram[0]=0, ram[1]=1, ram[16]=1
    chk("rgb_px00", hist_rgb[t_run + 2], 12'h000);
    chk("rgb_px10", hist_rgb[t_run + 3], 12'hFFF);
    chk("rgb_px01", hist_rgb[t_run + 2 + HT], 12'hFFF);

    // Mid-frame enable glitch is ignored; drop at v=5 stops at frame end
    wait_pos(3*HT, "reach_v3");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_pos(5*HT, "reach_v5");
    t_v5 = cyc;
    enable = 1'b0;
    t_idle = -1;
    for (int i = 0; i < FRAME + 10 && t_idle < 0; i++) begin
      @(negedge clk);
      if (!m_run) t_idle = cyc;
    end
    chk("stop_at_frame_end", t_idle - t_v5, 299);
    repeat (10) @(negedge clk);
    chk_idle_outputs("stopped");

    // Asynchronous reset mid-frame at (8,6)
    enable = 1'b1;
    wait_pos(6*HT + 8, "reach_h8_v6");
    #2 resetn = 1'b0;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    #2 resetn = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_idle_rd_en", fb_if.rd_en, 0);
    chk("post_reset_idle_hsync", vga_hsync, 1);

    // Restart from address 0
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_rd_en", fb_if.rd_en, 1);
    chk("restart_addr", fb_if.rd_addr, 0);
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Read side of the 1-bit framebuffer that sample_to_pixel writes.
- Generates 640x480@60 VGA timing from a single 25 MHz pixel clock.
- Issues sequential framebuffer read addresses and maps each returned bit to a 12-bit colour.
- Drives hsync, vsync and RGB to the VGA DAC pins, with a frame_start pulse and a vblank flag so the writer side can coordinate.

Parameters:
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines per frame
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- ADDR_WIDTH, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT) = 19, framebuffer address width
- RD_LATENCY, 1, framebuffer read latency (cycles)
- FG_COLOR, 12'hFFF, {R,G,B} output for a pixel bit of 1 (a 0 bit outputs 12'h000)

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  request scanout; sampled every cycle
- rd_addr  out  ADDR_WIDTH  framebuffer read address
- rd_en  out  1  framebuffer read enable
- rd_data  in  1  framebuffer pixel, valid RD_LATENCY cycles after rd_en
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vblank  out  1  high while output stage is outside the active area
- frame_start  out  1  one-cycle pulse with first active pixel of each frame

Behaviour:
Reset (async, active-low):
- state=IDLE; h_cnt=0, v_cnt=0, addr_cnt=0; pipeline cleared.
- Outputs: rd_en=0, rd_addr=0, vga_hsync=1, vga_vsync=1, rgb=0, vblank=1, frame_start=0.

Counters:
- H_TOTAL=800: h_cnt runs 0..799.
- V_TOTAL=525: v_cnt advances when h_cnt wraps and runs 0..524.
- active = (h_cnt<640) && (v_cnt<480).

State machine:
- IDLE: counters held at 0; rd_en=0; outputs hold reset values. Go to RUN on the cycle enable=1 is sampled.
- RUN: counters advance every cycle.
- At the (799,524) wrap: if enable=0, go to IDLE; else continue RUN. Scanout always stops on a frame boundary, never mid-frame.

Read side (stage 0):
- rd_en = (state==RUN) && active, decoded from registered state.
- rd_addr = addr_cnt.
- addr_cnt increments on every cycle with rd_en=1; clears to 0 at the (799,524) wrap and on RUN->IDLE.
- rd_addr therefore equals v*640+h during active pixels. Maximum issued address is 307199; the counter never wraps mid-frame.

Output pipeline:
- Total latency RD_LATENCY+1 (=2) from counter state to registered VGA outputs.
- Stage 1: rd_data valid.
- Stage 2: outputs registered.
  - rgb = rd_data ? FG_COLOR : 0 when the delayed active flag is set, else 0 (blanking is forced).
  - vga_hsync = 0 iff delayed h in [656,752).
  - vga_vsync = 0 iff delayed v in [490,492).
  - vblank = ~delayed active.
  - frame_start = 1 iff delayed (h,v)==(0,0) in RUN.
- Sync, colour and frame_start are mutually aligned.

Boundary conditions:
- enable toggling mid-frame: ignored until the frame boundary.
- After RUN->IDLE, the 2-cycle pipeline drains, then outputs return to idle values.
- rd_data outside valid slots: ignored (masked by the delayed active flag).
- resetn low mid-frame: immediate return to reset values. After release the block stays in IDLE until enable is sampled high.

Decomposition:
- Package vga_pkg: H/V timing constants, H_TOTAL/V_TOTAL, sync polarity constants, colour width localparams.
- Sub-module vga_timing: h/v counters, active/hsync/vsync decode, frame-wrap flag.
- framebuffer_scanout owns the FSM, address counter, latency pipeline and colour mapping.

Test Plan:
1. Reset, enable=1, rd_data=0 -> first vga_hsync low edge 656+2 cycles after RUN entry; low for 96 cycles; period 800; rgb=0 throughout.
2. Run 2 frames -> vga_vsync low exactly 1600 cycles per frame; frame period 420000 cycles; frame_start pulses once per frame, 420000 apart.
3. Address check -> per frame exactly 307200 rd_en cycles; line 1 pixel 0 has rd_addr=640; last rd_addr=307199; rd_en=0 throughout blanking.
4. Behavioural framebuffer model with 1-cycle latency loaded with a checkerboard (ram[i]=((i/640)+i)%2) -> vga_r/g/b = F/F/F on 1-bits and 0 otherwise, aligned 2 cycles after rd_addr; pixel (0,0) output coincides with frame_start.
5. enable deasserted at v=100 -> frame completes through (799,524); then IDLE with rd_en=0, vga_hsync=vga_vsync=1, vblank=1, rgb=0.
6. resetn pulsed low at h=300,v=200 -> outputs take reset values asynchronously; after release, block stays IDLE until enable=1, then restarts at rd_addr=0.
